// File: rtl/afe_tot_meas_if.sv
// afe_tot_meas_if: groups the trigger/discriminator inputs and the readout bus
// of the TOT measurement stage.
//   INJ_IN, COMP     : asynchronous trigger and discriminator inputs
//   HIT              : synchronised COMP
//   RD_EN            : one-cycle pop request from the SPI readout
//   DATA, VALID      : FIFO head record {TOA, TOT} and not-empty flag
//   OVF, CLR_OVF     : sticky overflow flag and its synchronous clear
// master = stimulus/readout side, slave = measurement stage.
interface afe_tot_meas_if #(
  parameter int unsigned CNT_W = 8
);
  logic               INJ_IN;
  logic               COMP;
  logic               HIT;
  logic               RD_EN;
  logic [2*CNT_W-1:0] DATA;
  logic               VALID;
  logic               OVF;
  logic               CLR_OVF;

  modport master (
    output INJ_IN, COMP, RD_EN, CLR_OVF,
    input  HIT, DATA, VALID, OVF
  );

  modport slave (
    input  INJ_IN, COMP, RD_EN, CLR_OVF,
    output HIT, DATA, VALID, OVF
  );
endinterface

// File: rtl/afe_tot_meas.sv
// afe_tot_meas: time-over-threshold front stage. Synchronises the injection
// trigger and discriminator, measures TOA (injection to comparator rise) and
// TOT (comparator high time) in CLK cycles and buffers {TOA, TOT} records in
// a small FIFO popped by the SPI readout.
//   CLK   : system clock
//   RST_B : asynchronous active-low reset
//   bus   : afe_tot_meas_if slave modport (see interface header)
module afe_tot_meas #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           CLK,
  input logic           RST_B,
  afe_tot_meas_if.slave bus
);

  localparam int unsigned REC_W = 2 * CNT_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, TOT} state_t;

  // bit0/bit1 form the synchroniser, bit2 is the edge-detect history
  logic [2:0]       inj_sync_q, inj_sync_d;
  logic [2:0]       comp_sync_q, comp_sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] toa_q, toa_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [REC_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;

  logic             inj_rise, comp_rise, comp_fall;
  logic [CNT_W-1:0] toa_inc;
  logic             push;
  logic [REC_W-1:0] push_rec;
  logic [PW-1:0]    count;
  logic             empty, full, pop, wr_en, drop;

  assign inj_rise  = inj_sync_q[1] & ~inj_sync_q[2];
  assign comp_rise = comp_sync_q[1] & ~comp_sync_q[2];
  assign comp_fall = ~comp_sync_q[1] & comp_sync_q[2];
  assign toa_inc   = toa_q + CNT_W'(1);

  always_comb begin
    inj_sync_d  = {inj_sync_q[1:0], bus.INJ_IN};
    comp_sync_d = {comp_sync_q[1:0], bus.COMP};
    state_d     = state_q;
    toa_d       = toa_q;
    tot_d       = tot_q;
    push        = 1'b0;
    push_rec    = '0;

    unique case (state_q)
      IDLE: begin
        if (inj_rise) begin
          toa_d = '0;
          if (comp_rise) begin
            tot_d   = CNT_W'(1);
            state_d = TOT;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        // The cycle of the COMP rise still counts toward TOA, so the frozen
        // value equals the cycle distance between the two detect cycles.
        toa_d = inj_rise ? '0 : toa_inc;
        if (comp_rise) begin
          tot_d   = CNT_W'(1);
          state_d = TOT;
        end else if (!inj_rise && toa_inc == CNT_MAX) begin
          push     = 1'b1;
          push_rec = {CNT_MAX, {CNT_W{1'b0}}};
          state_d  = IDLE;
        end
      end
      TOT: begin
        if (comp_fall) begin
          push     = 1'b1;
          push_rec = {toa_q, tot_q};
          state_d  = IDLE;
        end else if (comp_sync_q[1] && tot_q != CNT_MAX) begin
          tot_d = tot_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a pop frees a slot in the same cycle, so push-while-full only drops
  // when no pop accompanies it; a pop on an empty FIFO is never taken.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == PW'(FIFO_DEPTH));
    pop      = bus.RD_EN & ~empty;
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_rec;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    ovf_d = drop | (ovf_q & ~bus.CLR_OVF);
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      inj_sync_q  <= '0;
      comp_sync_q <= '0;
      state_q     <= IDLE;
      toa_q       <= '0;
      tot_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      inj_sync_q  <= inj_sync_d;
      comp_sync_q <= comp_sync_d;
      state_q     <= state_d;
      toa_q       <= toa_d;
      tot_q       <= tot_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.HIT   = comp_sync_q[1];
  assign bus.VALID = ~empty;
  assign bus.DATA  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.OVF   = ovf_q;

endmodule
